// File: rtl/lock_ctrl.sv
// lock_ctrl: six-digit keypad lock with external comparator, timed open window,
// password change while open, and lockout after repeated failed attempts.
module lock_ctrl #(
    parameter logic [23:0] INIT_PW     = 24'h123456,
    parameter logic [15:0] OPEN_CYCLES = 16'd1000,
    parameter logic [15:0] LOCK_CYCLES = 16'd5000,
    parameter logic [1:0]  MAX_TRIES   = 2'd3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        judge_ok,
    output logic        judge_en,
    output logic [23:0] entry_pw,
    output logic [23:0] stored_pw,
    output logic [2:0]  digit_cnt,
    output logic        unlock,
    output logic        err,
    output logic        alarm
);
    typedef enum logic [2:0] {IDLE, ENTRY, CHK0, CHK1, OPEN, SETPW, LOCK} state_t;

    state_t      state, state_d;
    logic [23:0] entry_d, stored_d, ins_pw;
    logic [2:0]  cnt_d;
    logic [1:0]  fail, fail_d, fail_next;
    logic [15:0] timer, timer_d;
    logic [4:0]  slot_lsb;
    logic        err_d, fail_now, is_digit, can_digit, k_enter, k_clear, k_set, expire;
    logic [1:0]  rst_sync;
    logic        rst_core_n;

    // Assertion propagates asynchronously; release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};

    assign rst_core_n = rst_sync[1];

    assign judge_en = (state == CHK0) || (state == CHK1);
    assign unlock   = state == OPEN;
    assign alarm    = state == LOCK;

    always_comb begin
        state_d   = state;
        entry_d   = entry_pw;
        cnt_d     = digit_cnt;
        stored_d  = stored_pw;
        fail_d    = fail;
        timer_d   = timer;
        err_d     = 1'b0;
        fail_now  = 1'b0;
        is_digit  = key_valid && (key_code <= 4'd9);
        can_digit = is_digit && (digit_cnt < 3'd6);
        k_enter   = key_valid && (key_code == 4'hA);
        k_clear   = key_valid && (key_code == 4'hB);
        k_set     = key_valid && (key_code == 4'hC);
        expire    = ((state == OPEN) || (state == LOCK)) && (timer <= 16'd1);
        fail_next = fail + 2'd1;
        // Slot digit_cnt+1 counts from the most significant nibble.
        slot_lsb  = {3'd5 - digit_cnt, 2'b00};
        ins_pw    = entry_pw;
        ins_pw[slot_lsb +: 4] = key_code;
        case (state)
            IDLE: begin
                if (can_digit) begin
                    entry_d = ins_pw;
                    cnt_d   = digit_cnt + 3'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (can_digit) begin
                    entry_d = ins_pw;
                    cnt_d   = digit_cnt + 3'd1;
                end else if (k_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (k_enter) begin
                    if (digit_cnt == 3'd6) state_d = CHK0;
                    else                   fail_now = 1'b1;
                end
            end
            CHK0: state_d = CHK1;
            CHK1: begin
                if (judge_ok) begin
                    state_d = OPEN;
                    fail_d  = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = OPEN_CYCLES;
                end else begin
                    fail_now = 1'b1;
                end
            end
            OPEN: begin
                if (expire) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (k_set) begin
                    state_d = SETPW;
                    timer_d = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer - 16'd1;
                end
            end
            SETPW: begin
                if (can_digit) begin
                    entry_d = ins_pw;
                    cnt_d   = digit_cnt + 3'd1;
                end else if (k_enter && digit_cnt == 3'd6) begin
                    stored_d = entry_pw;
                    entry_d  = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (k_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (expire) begin
                    state_d = IDLE;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fail_now) begin
            err_d   = 1'b1;
            entry_d = '0;
            cnt_d   = '0;
            fail_d  = fail_next;
            state_d = (fail_next == MAX_TRIES) ? LOCK : IDLE;
            timer_d = (fail_next == MAX_TRIES) ? LOCK_CYCLES : 16'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state     <= IDLE;
            entry_pw  <= '0;
            stored_pw <= INIT_PW;
            digit_cnt <= '0;
            fail      <= '0;
            timer     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            entry_pw  <= entry_d;
            stored_pw <= stored_d;
            digit_cnt <= cnt_d;
            fail      <= fail_d;
            timer     <= timer_d;
            err       <= err_d;
        end
    end
endmodule
